// File: rtl/elevator_nfloor_ctrl_if.sv
// Call/status bundle for the N-floor elevator controller.
// The master side drives calls and door/lock controls; the slave side is the controller.
interface elevator_nfloor_ctrl_if #(
    parameter int unsigned FLOORS  = 4,
    parameter int unsigned FLOOR_W = 2
);
    logic [FLOORS-1:0]  req;
    logic               hold;
    logic               lock;
    logic               unlock;
    logic [FLOOR_W-1:0] floor_idx;
    logic [FLOORS-1:0]  floor_onehot;
    logic               moving_up;
    logic               moving_down;
    logic               door_open;
    logic               locked;
    logic [FLOORS-1:0]  pending;

    modport master (
        output req, hold, lock, unlock,
        input  floor_idx, floor_onehot, moving_up, moving_down, door_open, locked, pending
    );

    modport slave (
        input  req, hold, lock, unlock,
        output floor_idx, floor_onehot, moving_up, moving_down, door_open, locked, pending
    );
endinterface

// File: rtl/elevator_nfloor_ctrl.sv
// SCAN-scheduled N-floor elevator controller with door timer and lock mode.
// Optional build macro ELEV_LOCK_FLUSH_EN: drop all pending calls on entry to LOCKED.
module elevator_nfloor_ctrl #(
    parameter int unsigned FLOORS        = 4,
    parameter int unsigned FLOOR_W       = 2,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input logic                   clk,
    input logic                   reset,
    elevator_nfloor_ctrl_if.slave bus
);

    localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DLOAD = DW'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StDoorOpen,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               lock_lat_q, lock_lat_d;
    logic               dir_down_q, dir_down_d;
    logic [FLOORS-1:0]  onehot_q;
    logic               mv_up_q, mv_dn_q, door_q, locked_q;

    logic [FLOORS-1:0]  pend_in;
    logic [FLOORS-1:0]  cur_oh, up_oh, dn_oh;
    logic [FLOOR_W-1:0] floor_up, floor_dn;
    logic               enter_lock;

    function automatic logic [FLOORS-1:0] to_onehot(input int f);
        logic [FLOORS-1:0] oh;
        for (int i = 0; i < int'(FLOORS); i++) begin
            oh[i] = (i == f);
        end
        return oh;
    endfunction

    function automatic logic has_above(input logic [FLOORS-1:0] p, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (i > f && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic has_below(input logic [FLOORS-1:0] p, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (i < f && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    assign floor_up = floor_q + FLOOR_W'(1);
    assign floor_dn = floor_q - FLOOR_W'(1);
    assign cur_oh   = to_onehot(int'(floor_q));
    assign up_oh    = to_onehot(int'(floor_up));
    assign dn_oh    = to_onehot(int'(floor_dn));
    assign pend_in  = pending_q | bus.req;

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        pending_d  = pending_q;
        tcnt_d     = tcnt_q;
        dcnt_d     = dcnt_q;
        lock_lat_d = lock_lat_q;
        dir_down_d = dir_down_q;
        enter_lock = 1'b0;

        case (state_q)
            StIdle: begin
                pending_d = pend_in;
                // Decisions use the latched register; this cycle's req is only captured.
                if (bus.lock) begin
                    enter_lock = 1'b1;
                end else if ((pending_q & cur_oh) != '0) begin
                    pending_d = pend_in & ~cur_oh;
                    dcnt_d    = DLOAD;
                    state_d   = StDoorOpen;
                end else if (dir_down_q && has_below(pending_q, int'(floor_q))) begin
                    tcnt_d  = '0;
                    state_d = StMoveDown;
                end else if (has_above(pending_q, int'(floor_q))) begin
                    tcnt_d     = '0;
                    dir_down_d = 1'b0;
                    state_d    = StMoveUp;
                end else if (has_below(pending_q, int'(floor_q))) begin
                    tcnt_d     = '0;
                    dir_down_d = 1'b1;
                    state_d    = StMoveDown;
                end
            end

            StMoveUp: begin
                pending_d = pend_in;
                if (bus.lock) lock_lat_d = 1'b1;
                if (floor_q == TOP) begin
                    state_d = StIdle;
                end else if (tcnt_q == TLAST) begin
                    tcnt_d  = '0;
                    floor_d = floor_up;
                    if (lock_lat_q || bus.lock) begin
                        enter_lock = 1'b1;
                    end else if ((pend_in & up_oh) != '0) begin
                        pending_d = pend_in & ~up_oh;
                        dcnt_d    = DLOAD;
                        state_d   = StDoorOpen;
                    end else if (!has_above(pend_in, int'(floor_up))) begin
                        state_d = StIdle;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            StMoveDown: begin
                pending_d = pend_in;
                if (bus.lock) lock_lat_d = 1'b1;
                if (floor_q == '0) begin
                    state_d = StIdle;
                end else if (tcnt_q == TLAST) begin
                    tcnt_d  = '0;
                    floor_d = floor_dn;
                    if (lock_lat_q || bus.lock) begin
                        enter_lock = 1'b1;
                    end else if ((pend_in & dn_oh) != '0) begin
                        pending_d = pend_in & ~dn_oh;
                        dcnt_d    = DLOAD;
                        state_d   = StDoorOpen;
                    end else if (!has_below(pend_in, int'(floor_dn))) begin
                        state_d = StIdle;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            StDoorOpen: begin
                // A call for this floor while the door is open just extends the door time.
                pending_d = pend_in & ~cur_oh;
                if (bus.lock && !bus.hold) begin
                    enter_lock = 1'b1;
                end else if (bus.hold || (bus.req & cur_oh) != '0) begin
                    dcnt_d = DLOAD;
                end else if (dcnt_q <= DW'(1)) begin
                    dcnt_d  = '0;
                    state_d = StIdle;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end

            StLocked: begin
                if (bus.unlock && !bus.lock) state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        if (enter_lock) begin
            state_d    = StLocked;
            lock_lat_d = 1'b0;
            tcnt_d     = '0;
            dcnt_d     = '0;
`ifdef ELEV_LOCK_FLUSH_EN
            pending_d  = '0;
`endif
        end
    end

    // Output flops are decoded from next-state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            floor_q    <= '0;
            pending_q  <= '0;
            tcnt_q     <= '0;
            dcnt_q     <= '0;
            lock_lat_q <= 1'b0;
            dir_down_q <= 1'b0;
            onehot_q   <= FLOORS'(1);
            mv_up_q    <= 1'b0;
            mv_dn_q    <= 1'b0;
            door_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            pending_q  <= pending_d;
            tcnt_q     <= tcnt_d;
            dcnt_q     <= dcnt_d;
            lock_lat_q <= lock_lat_d;
            dir_down_q <= dir_down_d;
            onehot_q   <= to_onehot(int'(floor_d));
            mv_up_q    <= (state_d == StMoveUp);
            mv_dn_q    <= (state_d == StMoveDown);
            door_q     <= (state_d == StDoorOpen);
            locked_q   <= (state_d == StLocked);
        end
    end

    assign bus.floor_idx    = floor_q;
    assign bus.floor_onehot = onehot_q;
    assign bus.moving_up    = mv_up_q;
    assign bus.moving_down  = mv_dn_q;
    assign bus.door_open    = door_q;
    assign bus.locked       = locked_q;
    assign bus.pending      = pending_q;

    a_one_direction: assert property (@(posedge clk) disable iff (reset)
        !(mv_up_q && mv_dn_q));
    a_floor_range: assert property (@(posedge clk) disable iff (reset)
        int'(floor_q) < int'(FLOORS));

endmodule

// File: tb/tb_elevator_nfloor_ctrl.sv
// Directed, table-driven bench for elevator_nfloor_ctrl (FLOORS=4, TRAVEL=4, DOOR=3).
module tb_elevator_nfloor_ctrl;

`ifdef ELEV_LOCK_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    elevator_nfloor_ctrl_if #(.FLOORS(4), .FLOOR_W(2)) bus ();

    elevator_nfloor_ctrl #(
        .FLOORS       (4),
        .FLOOR_W      (2),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       hold, lock, unlock;
        int         cycles;
        int         ef;
        logic       eu, ed, eo, el;
        logic [3:0] ep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rs, input logic [3:0] rq, input logic h, input logic l,
                       input logic u, input int c, input int ef, input logic eu,
                       input logic ed, input logic eo, input logic el, input logic [3:0] ep);
        vec_t t;
        t.rst = rs; t.req = rq; t.hold = h; t.lock = l; t.unlock = u; t.cycles = c;
        t.ef = ef; t.eu = eu; t.ed = ed; t.eo = eo; t.el = el; t.ep = ep;
        vecs.push_back(t);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rq, input logic h, input logic l, input logic u);
        bus.req = rq; bus.hold = h; bus.lock = l; bus.unlock = u;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    task automatic check(input string nm, input int ef, input logic eu, input logic ed,
                         input logic eo, input logic el, input logic [3:0] ep);
        logic [15:0] act, exp;
        act = {bus.floor_idx, bus.floor_onehot, bus.moving_up, bus.moving_down,
               bus.door_open, bus.locked, bus.pending};
        exp = {2'(ef), 4'(1 << ef), eu, ed, eo, el, ep};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (floor,onehot,up,dn,door,lock,pend)",
                     nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0] lp;
        lp = FLUSH ? 4'b0000 : 4'b1000;

        //   rst req     h  l  u  cyc fl up dn dr lk pend
        // single call to the top floor
        add(1, 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 3, 0, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 4, 2, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 4, 3, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 2, 3, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 4'b0000);
        // hold keeps the door open 5+3 cycles
        add(0, 4'b1000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 1, 3, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 5, 3, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 2, 3, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 4'b0000);
        // two stops on the way up
        add(1, 4'b0110, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0110);
        add(0, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0110);
        add(0, 4'b0000, 0, 0, 0, 4, 1, 0, 0, 1, 0, 4'b0100);
        add(0, 4'b0000, 0, 0, 0, 3, 1, 0, 0, 0, 0, 4'b0100);
        add(0, 4'b0000, 0, 0, 0, 1, 1, 1, 0, 0, 0, 4'b0100);
        add(0, 4'b0000, 0, 0, 0, 4, 2, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 3, 2, 0, 0, 0, 0, 4'b0000);
        // SCAN: calls on both sides, keep going up first, then sweep down to 0
        add(0, 4'b1001, 0, 0, 0, 1, 2, 0, 0, 0, 0, 4'b1001);
        add(0, 4'b0000, 0, 0, 0, 1, 2, 1, 0, 0, 0, 4'b1001);
        add(0, 4'b0000, 0, 0, 0, 4, 3, 0, 0, 1, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 0, 3, 3, 0, 0, 0, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 0, 1, 3, 0, 1, 0, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 0, 4, 2, 0, 1, 0, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 0, 8, 0, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 0, 3, 0, 0, 0, 0, 0, 4'b0000);
        // lock pulsed mid-travel 0->1 with a call pending at floor 3
        add(0, 4'b1000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 2, 0, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 1, 0, 1, 0, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 0, 2, 1, 0, 0, 0, 1, lp);
        add(0, 4'b0100, 0, 0, 0, 2, 1, 0, 0, 0, 1, lp);
        add(0, 4'b0000, 0, 1, 1, 2, 1, 0, 0, 0, 1, lp);
        add(0, 4'b0000, 0, 0, 1, 1, 1, 0, 0, 0, 0, lp);
        add(0, 4'b0000, 0, 0, 0, 1, 1, !FLUSH, 0, 0, 0, lp);
        add(0, 4'b0000, 0, 0, 0, 11, FLUSH ? 1 : 3, 0, 0, 0, 0, 4'b0000);

        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #2 check("async_reset", 0, 0, 0, 0, 0, 4'b0000);
        run(1);
        reset = 1'b0;
        run(1);
        check("after_reset", 0, 0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].req, vecs[i].hold, vecs[i].lock, vecs[i].unlock);
            run(vecs[i].cycles);
            check($sformatf("vec[%0d]", i), vecs[i].ef, vecs[i].eu, vecs[i].ed,
                  vecs[i].eo, vecs[i].el, vecs[i].ep);
        end

        // lock beats a same-cycle call in IDLE
        do_reset();
        drive(4'b0100, 1'b0, 1'b1, 1'b0);
        run(1);
        check("lock_vs_req", 0, 0, 0, 0, 1, FLUSH ? 4'b0000 : 4'b0100);
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        run(3);
        check("lock_no_motion", 0, 0, 0, 0, 1, FLUSH ? 4'b0000 : 4'b0100);

        // reset asserted between clock edges while travelling up
        do_reset();
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        run(1);
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        run(6);
        check("pre_midreset", 1, 1, 0, 0, 0, 4'b1000);
        #3 reset = 1'b1;
        #1 check("mid_travel_reset", 0, 0, 0, 0, 0, 4'b0000);
        run(1);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
